// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel stream filter: output modes, FSM states and
// gradient width guard.
package sobel_pkg;

  localparam logic [1:0] MODE_MAG    = 2'd0;
  localparam logic [1:0] MODE_THRESH = 2'd1;
  localparam logic [1:0] MODE_H      = 2'd2;
  localparam logic [1:0] MODE_V      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Extra bits above PIX_W so a signed gradient sum (|sum| <= 4*max) cannot overflow.
  localparam int GRAD_GUARD = 4;

endpackage

// File: rtl/sobel_line_buffer.sv
// Enable-gated shift row holding the tail of one image line between window rows.
// Contents are intentionally not reset; stale data is masked downstream as border.
module sobel_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] taps_r [DEPTH];

  // Shift the row by one entry per enabled cycle.
  always_ff @(posedge clock) begin
    if (en) begin
      taps_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps_r[i] <= taps_r[i-1];
      end
    end
  end

  assign dout = taps_r[DEPTH-1];

endmodule

// File: rtl/sobel_stream_filter.sv
// Flow-controlled 3x3 Sobel edge detector: window, gradient, abs/mode and output
// stages, zeroed borders and an end-of-frame flush giving IMG_W*IMG_H beats per frame.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int OUT_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int SHIFT = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               in_sof,
  input  logic [1:0]         mode,
  input  logic [PIX_W+3:0]   threshold,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_pixel,
  output logic               out_sof,
  output logic               out_eol
);

  localparam int GW = PIX_W + GRAD_GUARD;
  localparam int AW = GW - 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t            state_r, state_nxt_s;
  logic              in_ready_r;
  logic [CW-1:0]     col_r, cc_r;
  logic [RW-1:0]     row_r, cr_r;
  logic              accept_s, start_s, frame_beat_s, emit_s, shift_s;
  logic              fill_done_s, last_in_s, last_ctr_s, border_s;

  logic [PIX_W-1:0]  p00_r, p01_r, p02_r, p10_r, p11_r, p12_r, p20_r, p21_r, p22_r;
  logic [PIX_W-1:0]  lb0_q_s, lb1_q_s;

  logic              w_valid_r, w_border_r, w_sof_r, w_eol_r;
  logic [1:0]        w_mode_r;
  logic [GW-1:0]     w_thr_r;
  logic              s1_valid_r, s1_border_r, s1_sof_r, s1_eol_r;
  logic [1:0]        s1_mode_r;
  logic [GW-1:0]     s1_thr_r;
  logic signed [GW-1:0] s1_h_r, s1_v_r, h_s, v_s;
  logic              s2_valid_r, s2_border_r, s2_sof_r, s2_eol_r;
  logic [OUT_W-1:0]  s2_pix_r, res_s;
  logic [AW-1:0]     h_abs_s, v_abs_s;
  logic [GW-1:0]     mag_s, sel_s, shr_s;

  logic              out_valid_r, out_sof_r, out_eol_r;
  logic [OUT_W-1:0]  out_pixel_r;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{GRAD_GUARD{1'b0}}, p});
  endfunction

  assign accept_s     = in_valid & in_ready_r;
  assign start_s      = accept_s & in_sof;
  assign frame_beat_s = accept_s & (in_sof | (state_r == ST_FILL) | (state_r == ST_RUN));
  assign emit_s       = (accept_s & ~in_sof & (state_r == ST_RUN)) | (state_r == ST_FLUSH);
  assign shift_s      = frame_beat_s | (state_r == ST_FLUSH);
  assign fill_done_s  = (col_r == '0) && (row_r == RW'(1));
  assign last_in_s    = (col_r == CW'(IMG_W-1)) && (row_r == RW'(IMG_H-1));
  assign last_ctr_s   = (cc_r == CW'(IMG_W-1)) && (cr_r == RW'(IMG_H-1));
  // Flush cycles only ever cover border centres, but force it so stale data never leaks.
  assign border_s     = (cr_r == '0) | (cr_r == RW'(IMG_H-1)) | (cc_r == '0) |
                        (cc_r == CW'(IMG_W-1)) | (state_r == ST_FLUSH);

  // FSM state register and registered ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s != ST_FLUSH);
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_s) state_nxt_s = ST_FILL; else state_nxt_s = ST_IDLE;
      ST_FILL: begin
        if (start_s)                         state_nxt_s = ST_FILL;
        else if (accept_s && fill_done_s)    state_nxt_s = ST_RUN;
        else                                 state_nxt_s = ST_FILL;
      end
      ST_RUN: begin
        if (start_s)                         state_nxt_s = ST_FILL;
        else if (accept_s && last_in_s)      state_nxt_s = ST_FLUSH;
        else                                 state_nxt_s = ST_RUN;
      end
      ST_FLUSH: if (last_ctr_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_FLUSH;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Input position counters and output-centre counters (raster order, wrapping).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_r <= '0;
      row_r <= '0;
      cc_r  <= '0;
      cr_r  <= '0;
    end else begin
      if (start_s) begin
        col_r <= CW'(1);
        row_r <= '0;
      end else if (frame_beat_s) begin
        if (col_r == CW'(IMG_W-1)) begin
          col_r <= '0;
          row_r <= (row_r == RW'(IMG_H-1)) ? '0 : row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
      if (start_s) begin
        cc_r <= '0;
        cr_r <= '0;
      end else if (emit_s) begin
        if (cc_r == CW'(IMG_W-1)) begin
          cc_r <= '0;
          cr_r <= (cr_r == RW'(IMG_H-1)) ? '0 : cr_r + RW'(1);
        end else begin
          cc_r <= cc_r + CW'(1);
        end
      end
    end
  end

  sobel_line_buffer #(.DATA_W(PIX_W), .DEPTH(IMG_W-3)) u_lb0 (
    .clock(clock), .en(shift_s), .din(p20_r), .dout(lb0_q_s)
  );
  sobel_line_buffer #(.DATA_W(PIX_W), .DEPTH(IMG_W-3)) u_lb1 (
    .clock(clock), .en(shift_s), .din(p10_r), .dout(lb1_q_s)
  );

  // 3x3 window shift; p22 is the newest pixel, p11 the centre.
  always_ff @(posedge clock) begin
    if (shift_s) begin
      p22_r <= in_pixel; p21_r <= p22_r; p20_r <= p21_r;
      p12_r <= lb0_q_s;  p11_r <= p12_r; p10_r <= p11_r;
      p02_r <= lb1_q_s;  p01_r <= p02_r; p00_r <= p01_r;
    end
  end

  assign h_s = (ext(p02_r) + (ext(p12_r) <<< 1'b1) + ext(p22_r)) -
               (ext(p00_r) + (ext(p10_r) <<< 1'b1) + ext(p20_r));
  assign v_s = (ext(p20_r) + (ext(p21_r) <<< 1'b1) + ext(p22_r)) -
               (ext(p00_r) + (ext(p01_r) <<< 1'b1) + ext(p02_r));

  // Absolute values, mode select, shift and saturation.
  always_comb begin
    h_abs_s = s1_h_r[GW-1] ? AW'(-s1_h_r) : AW'(s1_h_r);
    v_abs_s = s1_v_r[GW-1] ? AW'(-s1_v_r) : AW'(s1_v_r);
    mag_s   = GW'(h_abs_s) + GW'(v_abs_s);
    case (s1_mode_r)
      MODE_H:  sel_s = GW'(h_abs_s);
      MODE_V:  sel_s = GW'(v_abs_s);
      default: sel_s = mag_s;
    endcase
    shr_s = sel_s >> SHIFT;
    if (s1_mode_r == MODE_THRESH) begin
      res_s = (mag_s >= s1_thr_r) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    end else if ((shr_s >> OUT_W) != '0) begin
      res_s = {OUT_W{1'b1}};
    end else begin
      res_s = OUT_W'(shr_s);
    end
  end

  // Pipeline: window metadata -> gradients -> mode result -> masked output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_valid_r  <= 1'b0; w_border_r  <= 1'b0; w_sof_r  <= 1'b0; w_eol_r  <= 1'b0;
      w_mode_r   <= 2'd0; w_thr_r     <= '0;
      s1_valid_r <= 1'b0; s1_border_r <= 1'b0; s1_sof_r <= 1'b0; s1_eol_r <= 1'b0;
      s1_mode_r  <= 2'd0; s1_thr_r    <= '0;   s1_h_r   <= '0;   s1_v_r   <= '0;
      s2_valid_r <= 1'b0; s2_border_r <= 1'b0; s2_sof_r <= 1'b0; s2_eol_r <= 1'b0;
      s2_pix_r   <= '0;
      out_valid_r <= 1'b0; out_pixel_r <= '0; out_sof_r <= 1'b0; out_eol_r <= 1'b0;
    end else begin
      w_valid_r   <= emit_s;
      w_border_r  <= border_s;
      w_sof_r     <= (cc_r == '0) && (cr_r == '0);
      w_eol_r     <= (cc_r == CW'(IMG_W-1));
      w_mode_r    <= mode;
      w_thr_r     <= threshold;
      s1_valid_r  <= w_valid_r;
      s1_border_r <= w_border_r;
      s1_sof_r    <= w_sof_r;
      s1_eol_r    <= w_eol_r;
      s1_mode_r   <= w_mode_r;
      s1_thr_r    <= w_thr_r;
      s1_h_r      <= h_s;
      s1_v_r      <= v_s;
      s2_valid_r  <= s1_valid_r;
      s2_border_r <= s1_border_r;
      s2_sof_r    <= s1_sof_r;
      s2_eol_r    <= s1_eol_r;
      s2_pix_r    <= res_s;
      out_valid_r <= s2_valid_r;
      out_pixel_r <= (s2_valid_r && !s2_border_r) ? s2_pix_r : {OUT_W{1'b0}};
      out_sof_r   <= s2_valid_r & s2_sof_r;
      out_eol_r   <= s2_valid_r & s2_eol_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_pixel = out_pixel_r;
  assign out_sof   = out_sof_r;
  assign out_eol   = out_eol_r;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter on an 8x6 image: table of whole-frame vectors
// plus hand-written abort and reset-during-flush sequences.
module tb_sobel_stream_filter;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int K_FLAT = 0, K_STEPH = 1, K_STEPV = 2, K_RAMP = 3, K_RNEG = 4;

  typedef struct {
    int          kind;
    logic [1:0]  mode;
    logic [11:0] thr;
    bit          gap;
    logic [7:0]  exp_in;
    logic [7:0]  exp_edge;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_sof, in_ready, out_valid, out_sof, out_eol;
  logic [7:0]  in_pixel, out_pixel;
  logic [1:0]  mode;
  logic [11:0] threshold;

  always #5 clock = ~clock;

  sobel_stream_filter #(.PIX_W(8), .OUT_W(8), .IMG_W(W), .IMG_H(H), .SHIFT(0)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof), .mode(mode), .threshold(threshold),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_sof(out_sof), .out_eol(out_eol)
  );

  int         cyc = 0;
  int         rdy_low = 0;
  logic [7:0] q_pix[$];
  logic       q_sof[$];
  logic       q_eol[$];
  int         q_cyc[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  vec_t       tbl[16];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (out_valid) begin
      q_pix.push_back(out_pixel);
      q_sof.push_back(out_sof);
      q_eol.push_back(out_eol);
      q_cyc.push_back(cyc);
    end
    if (!in_ready) rdy_low <= rdy_low + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int kind, input int r, input int c);
    case (kind)
      K_FLAT:  return 8'd100;
      K_STEPH: return (c >= 4) ? 8'd255 : 8'd0;
      K_STEPV: return (r >= 3) ? 8'd255 : 8'd0;
      K_RAMP:  return 8'(10 * c + 5 * r);
      K_RNEG:  return 8'(200 - 10 * c - 5 * r);
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] expv(input vec_t v, input int r, input int c);
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
    if ((v.kind == K_STEPH && (c == 3 || c == 4)) || (v.kind == K_STEPV && (r == 2 || r == 3)))
      return v.exp_edge;
    return v.exp_in;
  endfunction

  task automatic send_beat(input logic [7:0] p, input logic sof);
    int t;
    in_valid = 1'b1; in_pixel = p; in_sof = sof; t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clock); #1; t++;
    end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input int kind, input bit gap);
    for (int i = 0; i < N; i++) begin
      send_beat(pix(kind, i / W, i % W), i == 0);
      if (gap) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int base, input int r0);
    int t;
    int sp;
    t = 0;
    while (q_pix.size() < base + N && t < 600) begin
      @(posedge clock); t++;
    end
    chk({tag, " frame_complete"}, 32'(q_pix.size() >= base + N), 32'd1);
    if (q_pix.size() >= base + N) begin
      repeat (6) @(posedge clock);
      chk({tag, " beat_count"}, 32'(q_pix.size() - base), 32'(N));
      for (int i = 0; i < N; i++) begin
        chk($sformatf("%s pix r%0d c%0d", tag, i / W, i % W), 32'(q_pix[base+i]), 32'(expv(v, i / W, i % W)));
        chk($sformatf("%s sof %0d", tag, i), 32'(q_sof[base+i]), 32'(i == 0));
        chk($sformatf("%s eol %0d", tag, i), 32'(q_eol[base+i]), 32'(i % W == W - 1));
        if (i > 0) begin
          sp = (v.gap && i <= N - W - 2) ? 2 : 1;
          chk($sformatf("%s spacing %0d", tag, i), 32'(q_cyc[base+i] - q_cyc[base+i-1]), 32'(sp));
        end
      end
      chk({tag, " flush_ready_low"}, 32'(rdy_low - r0), 32'(W + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int r0;
    reset_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'd0;
    mode = 2'd0; threshold = 12'd0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_pixel", 32'(out_pixel), 32'd0);
    chk("reset out_sof", 32'(out_sof), 32'd0);
    chk("reset out_eol", 32'(out_eol), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    tbl[0]  = '{K_FLAT,  2'd0, 12'd0,    1'b0, 8'd0,   8'd0};
    tbl[1]  = '{K_STEPH, 2'd0, 12'd0,    1'b0, 8'd0,   8'd255};
    tbl[2]  = '{K_STEPH, 2'd1, 12'd1021, 1'b0, 8'd0,   8'd0};
    tbl[3]  = '{K_STEPH, 2'd1, 12'd1020, 1'b0, 8'd0,   8'd255};
    tbl[4]  = '{K_STEPH, 2'd0, 12'd0,    1'b1, 8'd0,   8'd255};
    tbl[5]  = '{K_STEPH, 2'd2, 12'd0,    1'b0, 8'd0,   8'd255};
    tbl[6]  = '{K_STEPH, 2'd3, 12'd0,    1'b0, 8'd0,   8'd0};
    tbl[7]  = '{K_STEPV, 2'd3, 12'd0,    1'b0, 8'd0,   8'd255};
    tbl[8]  = '{K_STEPV, 2'd2, 12'd0,    1'b0, 8'd0,   8'd0};
    tbl[9]  = '{K_RAMP,  2'd0, 12'd0,    1'b0, 8'd120, 8'd120};
    tbl[10] = '{K_RAMP,  2'd2, 12'd0,    1'b0, 8'd80,  8'd80};
    tbl[11] = '{K_RAMP,  2'd3, 12'd0,    1'b0, 8'd40,  8'd40};
    tbl[12] = '{K_RAMP,  2'd1, 12'd120,  1'b0, 8'd255, 8'd255};
    tbl[13] = '{K_RAMP,  2'd1, 12'd121,  1'b0, 8'd0,   8'd0};
    tbl[14] = '{K_RNEG,  2'd0, 12'd0,    1'b0, 8'd120, 8'd120};
    tbl[15] = '{K_FLAT,  2'd1, 12'd0,    1'b0, 8'd255, 8'd255};

    for (int k = 0; k < 16; k++) begin
      mode = tbl[k].mode;
      threshold = tbl[k].thr;
      base = q_pix.size();
      r0 = rdy_low;
      send_frame(tbl[k].kind, tbl[k].gap);
      check_frame($sformatf("vec%0d", k), tbl[k], base, r0);
    end

    // Abort after 20 beats: 11 beats were already emitted from the aborted frame.
    mode = 2'd0; threshold = 12'd0;
    base = q_pix.size();
    r0 = rdy_low;
    for (int i = 0; i < 20; i++) send_beat(pix(K_STEPH, i / W, i % W), i == 0);
    send_frame(K_STEPH, 1'b0);
    check_frame("abort", tbl[1], base + 11, r0);
    chk("abort stale sof", 32'(q_sof[base]), 32'd1);

    // Reset asserted during flush, then dropped non-sof beats, then a clean frame.
    send_frame(K_FLAT, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("flush out_valid", 32'(out_valid), 32'd1);
    chk("flush in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midflush reset out_valid", 32'(out_valid), 32'd0);
    chk("midflush reset in_ready", 32'(in_ready), 32'd1);
    chk("midflush reset out_pixel", 32'(out_pixel), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    base = q_pix.size();
    r0 = rdy_low;
    for (int i = 0; i < 5; i++) send_beat(8'd200, 1'b0);
    send_frame(K_FLAT, 1'b0);
    check_frame("post_reset", tbl[0], base, r0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
